// File: rtl/accumulator_sequencer.sv
// accumulator_sequencer: steps a bit-serial accumulator through
// SETUP, WIDTH serial BIT cycles and WRITE for each accepted operation.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   op_valid/op_ready     operation handshake (op_ready = state is IDLE)
//   op_code, operand      000 CLR, 001 LOAD, 010 ADD, 011 SUB, 100 INC,
//                         others NOP; both registered on accept
//   a2x .. sum_to_bus     registered accumulator control strobes
//   carry_out, sum_out    serial feedback from the accumulator
//   result_valid/ready    result handshake, result held until taken
//   result, result_carry  collected sum word and final carry
//   overflow              only with ACC_SEQ_OVERFLOW_EN defined:
//                         carry into MSB xor carry out of MSB
module accumulator_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] operand,
   output logic             a2x,
   output logic             areg,
   output logic             x_plus_one,
   output logic             x_clear,
   output logic             y_bus,
   output logic             bus,
   output logic             shifted,
   output logic             write_shift,
   output logic             clear,
   output logic             carry_in,
   output logic             sum_to_bus,
   input  logic             carry_out,
   input  logic             sum_out,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result,
   output logic             result_carry
`ifdef ACC_SEQ_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [2:0] OP_CLR  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_INC  = 3'b100;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_BIT,
      S_WRITE,
      S_DONE
   } state_t;

   typedef struct packed {
      logic a2x;
      logic areg;
      logic x_plus_one;
      logic x_clear;
      logic y_bus;
      logic bus;
      logic write_shift;
      logic clear;
      logic carry_in;
      logic sum_to_bus;
   } strobe_t;

   state_t           state_q;
   state_t           state_n;
   logic [IW-1:0]    idx_q;
   logic [IW-1:0]    idx_n;
   logic [2:0]       op_q;
   logic [2:0]       op_sel;
   logic [WIDTH-1:0] opnd_q;
   strobe_t          strb_q;
   strobe_t          strb_n;
   logic             valid_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;

   logic is_clr;
   logic is_load;
   logic is_add;
   logic is_sub;
   logic is_inc;
   logic is_nop;
   logic is_arith;
   logic first_bit_n;
   logic last_bit;
   logic accept;

   // In IDLE the op is still on the input bus; later it is the
   // registered copy, so SETUP strobes can be decided on accept.
   assign op_sel   = (state_q == S_IDLE) ? op_code : op_q;
   assign is_clr   = (op_sel == OP_CLR);
   assign is_load  = (op_sel == OP_LOAD);
   assign is_add   = (op_sel == OP_ADD);
   assign is_sub   = (op_sel == OP_SUB);
   assign is_inc   = (op_sel == OP_INC);
   assign is_arith = is_add | is_sub | is_inc;
   assign is_nop   = !(is_clr | is_load | is_arith);

   assign op_ready = (state_q == S_IDLE);
   assign accept   = op_valid && op_ready;
   assign last_bit = (idx_q == IW'(WIDTH - 1));

   always_comb begin
      state_n = state_q;
      idx_n   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               state_n = is_nop ? S_DONE : S_SETUP;
            end
            idx_n = '0;
         end
         S_SETUP: begin
            state_n = S_BIT;
            idx_n   = '0;
         end
         S_BIT: begin
            if (last_bit) begin
               state_n = S_WRITE;
            end else begin
               idx_n = idx_q + 1'b1;
            end
         end
         S_WRITE: begin
            state_n = S_DONE;
         end
         S_DONE: begin
            if (result_ready) begin
               state_n = S_IDLE;
            end
         end
         default: begin
            state_n = S_IDLE;
            idx_n   = '0;
         end
      endcase
   end

   // Strobes are registered: decode them for the state being
   // entered so they line up exactly with that state.
   assign first_bit_n = (idx_n == '0);

   always_comb begin
      strb_n = '0;
      case (state_n)
         S_SETUP: begin
            strb_n.x_clear = 1'b1;
            strb_n.clear   = is_clr;
            strb_n.a2x     = is_arith;
         end
         S_BIT: begin
            strb_n.y_bus      = is_load | is_add | is_sub;
            strb_n.areg       = is_arith;
            strb_n.bus        = ((is_load | is_add) & opnd_q[idx_n])
                              | (is_sub & ~opnd_q[idx_n]);
            strb_n.carry_in   = is_sub & first_bit_n;
            strb_n.x_plus_one = is_inc & first_bit_n;
         end
         S_WRITE: begin
            strb_n.sum_to_bus  = 1'b1;
            strb_n.write_shift = 1'b1;
         end
         default: begin
            strb_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         op_q     <= OP_CLR;
         opnd_q   <= '0;
         strb_q   <= '0;
         valid_q  <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         idx_q   <= idx_n;
         strb_q  <= strb_n;
         valid_q <= (state_n == S_DONE);
         if (accept) begin
            op_q     <= op_code;
            opnd_q   <= operand;
            result_q <= '0;
            carry_q  <= 1'b0;
         end
         if (state_q == S_BIT) begin
            result_q[idx_q] <= sum_out;
            if (last_bit) begin
               carry_q <= carry_out;
            end
         end
      end
   end

`ifdef ACC_SEQ_OVERFLOW_EN
   logic carry_pen_q;
   logic ovf_q;

   // Carry out of bit WIDTH-2 is the carry into the sign bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         carry_pen_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         if (accept) begin
            carry_pen_q <= 1'b0;
            ovf_q       <= 1'b0;
         end
         if (state_q == S_BIT) begin
            if (idx_q == IW'(WIDTH - 2)) begin
               carry_pen_q <= carry_out;
            end
            if (last_bit && is_arith) begin
               ovf_q <= carry_pen_q ^ carry_out;
            end
         end
      end
   end

   assign overflow = ovf_q;
`endif

   assign a2x          = strb_q.a2x;
   assign areg         = strb_q.areg;
   assign x_plus_one   = strb_q.x_plus_one;
   assign x_clear      = strb_q.x_clear;
   assign y_bus        = strb_q.y_bus;
   assign bus          = strb_q.bus;
   assign shifted      = 1'b0;
   assign write_shift  = strb_q.write_shift;
   assign clear        = strb_q.clear;
   assign carry_in     = strb_q.carry_in;
   assign sum_to_bus   = strb_q.sum_to_bus;
   assign result_valid = valid_q;
   assign result       = result_q;
   assign result_carry = carry_q;

endmodule
